// File: rtl/cdb_broadcast.sv
// CDB producer: one buffer slot per FU, rotating-priority pick of up to SS_SIZE
// results per cycle onto registered lanes. Optional CDB_NOTAG_DROP_EN drops tag-0 results.

module cdb_slot #(
  parameter int TAG_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] value_i,
  output logic              occ_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] value_o
);
  logic              occ_q, occ_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] value_q, value_d;

  // A refill at the same edge as the grant wins over the clear.
  always_comb begin
    occ_d   = occ_q;
    tag_d   = tag_q;
    value_d = value_q;
    if (flush_i) begin
      occ_d = 1'b0;
    end else if (load_i) begin
      occ_d   = 1'b1;
      tag_d   = tag_i;
      value_d = value_i;
    end else if (clear_i) begin
      occ_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q   <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      occ_q   <= occ_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  assign occ_o   = occ_q;
  assign tag_o   = tag_q;
  assign value_o = value_q;
endmodule

module cdb_broadcast #(
  parameter int NUM_FU  = 8,
  parameter int SS_SIZE = 3,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32,
  localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CNT_W  = $clog2(SS_SIZE + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_FU-1:0]           fu_done_valid,
  input  logic [NUM_FU*TAG_W-1:0]     fu_done_tag,
  input  logic [NUM_FU*DATA_W-1:0]    fu_done_value,
  output logic [NUM_FU-1:0]           fu_done_ready,
  output logic [SS_SIZE-1:0]          cdb_valid,
  output logic [SS_SIZE*TAG_W-1:0]    cdb_tag,
  output logic [SS_SIZE*DATA_W-1:0]   cdb_value,
  output logic [CNT_W-1:0]            cdb_count
);
  logic [NUM_FU-1:0][TAG_W-1:0]   in_tag;
  logic [NUM_FU-1:0][DATA_W-1:0]  in_val;
  logic [NUM_FU-1:0][TAG_W-1:0]   slot_tag;
  logic [NUM_FU-1:0][DATA_W-1:0]  slot_val;
  logic [NUM_FU-1:0]              occ, grant, load;

  logic [SS_SIZE-1:0][PTR_W-1:0]  lane_src;
  logic [CNT_W-1:0]               n_grant;
  logic [PTR_W-1:0]               last_idx;
  logic [PTR_W-1:0]               rr_q, rr_d;

  logic [SS_SIZE-1:0]             vld_q, vld_d;
  logic [SS_SIZE-1:0][TAG_W-1:0]  ltag_q, ltag_d;
  logic [SS_SIZE-1:0][DATA_W-1:0] lval_q, lval_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  assign in_tag = fu_done_tag;
  assign in_val = fu_done_value;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    logic keep;
`ifdef CDB_NOTAG_DROP_EN
    // Tag 0 has no destination: the handshake completes but nothing is held.
    assign keep = (in_tag[g] != '0);
`else
    assign keep = 1'b1;
`endif
    assign fu_done_ready[g] = !squash && (!occ[g] || grant[g]);
    assign load[g]          = fu_done_valid[g] && fu_done_ready[g] && keep;

    cdb_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_slot (
      .clk_i   (clock),
      .rst_ni  (reset),
      .flush_i (squash),
      .load_i  (load[g]),
      .clear_i (grant[g]),
      .tag_i   (in_tag[g]),
      .value_i (in_val[g]),
      .occ_o   (occ[g]),
      .tag_o   (slot_tag[g]),
      .value_o (slot_val[g])
    );
  end

  // Scan from rr_q; the k-th occupied slot found lands on lane k.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    lane_src = '0;
    n_grant  = '0;
    last_idx = rr_q;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_q) + k) % NUM_FU;
      if (occ[idx] && (int'(n_grant) < SS_SIZE)) begin
        grant[idx]        = 1'b1;
        lane_src[n_grant] = PTR_W'(idx);
        last_idx          = PTR_W'(idx);
        n_grant           = n_grant + CNT_W'(1);
      end
    end
  end

  always_comb begin
    vld_d  = '0;
    ltag_d = '0;
    lval_d = '0;
    cnt_d  = '0;
    rr_d   = rr_q;
    if (!squash) begin
      cnt_d = n_grant;
      for (int j = 0; j < SS_SIZE; j++) begin
        if (j < int'(n_grant)) begin
          vld_d[j]  = 1'b1;
          ltag_d[j] = slot_tag[lane_src[j]];
          lval_d[j] = slot_val[lane_src[j]];
        end
      end
      if (n_grant != '0) rr_d = PTR_W'((int'(last_idx) + 1) % NUM_FU);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q   <= '0;
      vld_q  <= '0;
      ltag_q <= '0;
      lval_q <= '0;
      cnt_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      vld_q  <= vld_d;
      ltag_q <= ltag_d;
      lval_q <= lval_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cdb_valid = vld_q;
  assign cdb_tag   = ltag_q;
  assign cdb_value = lval_q;
  assign cdb_count = cnt_q;
endmodule

// File: tb/tb_cdb_broadcast.sv
// Scoreboard bench for cdb_broadcast: stimulus pushes expected lane sets,
// a negedge monitor pops one per broadcast cycle and compares.
module tb_cdb_broadcast;
  localparam int NF = 8, SS = 3, TW = 7, DW = 32;

  logic clock = 1'b0, reset = 1'b0, squash = 1'b0;
  logic [NF-1:0]    fu_done_valid = '0;
  logic [NF*TW-1:0] fu_done_tag   = '0;
  logic [NF*DW-1:0] fu_done_value = '0;
  logic [NF-1:0]    fu_done_ready;
  logic [SS-1:0]    cdb_valid;
  logic [SS*TW-1:0] cdb_tag;
  logic [SS*DW-1:0] cdb_value;
  logic [1:0]       cdb_count;

  cdb_broadcast #(.NUM_FU(NF), .SS_SIZE(SS), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_done_valid(fu_done_valid), .fu_done_tag(fu_done_tag),
    .fu_done_value(fu_done_value), .fu_done_ready(fu_done_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_count(cdb_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       cnt;
    logic [SS-1:0]    vld;
    logic [SS*TW-1:0] tags;
    logic [SS*DW-1:0] vals;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic [TW-1:0] ftag[NF];
  logic [DW-1:0] fval[NF];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [NF-1:0] mask);
    fu_done_valid = mask;
    for (int i = 0; i < NF; i++) begin
      fu_done_tag[i*TW +: TW]   = ftag[i];
      fu_done_value[i*DW +: DW] = fval[i];
    end
  endtask

  task automatic push_exp(input int n, input int a, input int b, input int c);
    exp_t e;
    int s[3];
    s = '{a, b, c};
    e.cnt = 2'(n); e.vld = '0; e.tags = '0; e.vals = '0;
    for (int j = 0; j < n; j++) begin
      e.vld[j]            = 1'b1;
      e.tags[j*TW +: TW]  = ftag[s[j]];
      e.vals[j*DW +: DW]  = fval[s[j]];
    end
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && cdb_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_bcast: got valid=%b tag=%0h, expected no broadcast", cdb_valid, cdb_tag);
        end else begin
          e = exp_q.pop_front();
          chk("cdb_count", 128'(cdb_count), 128'(e.cnt));
          chk("cdb_valid", 128'(cdb_valid), 128'(e.vld));
          chk("cdb_tag",   128'(cdb_tag),   128'(e.tags));
          chk("cdb_value", 128'(cdb_value), 128'(e.vals));
        end
      end
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < NF; i++) begin
      ftag[i] = TW'(8'h10 + i);
      fval[i] = 32'hA000_0000 + i;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    chk("reset_valid", 128'(cdb_valid), 128'(0));
    chk("reset_count", 128'(cdb_count), 128'(0));
    chk("reset_ready", 128'(fu_done_ready), 128'(8'hFF));
    tick();

    // Overload: FU0-4 at once, rr=0
    present(8'h1F);
    push_exp(3, 0, 1, 2);
    push_exp(2, 3, 4, 0);
    tick();
    fu_done_valid = '0;
    chk("ovl_ready_busy", 128'(fu_done_ready), 128'(8'hE7));
    tick();
    chk("ovl_ready_drain", 128'(fu_done_ready), 128'(8'hFF));
    tick();
    chk("ovl_ready_idle", 128'(fu_done_ready), 128'(8'hFF));
    tick();

    // Rotation: rr=5, FU0,1,2,7
    present(8'h87);
    push_exp(3, 7, 0, 1);
    push_exp(1, 2, 0, 0);
    tick();
    fu_done_valid = '0;
    repeat (3) tick();

    // Single result with latency check
    ftag[0] = 7'h45; fval[0] = 32'hDEADBEEF;
    present(8'h01);
    push_exp(1, 0, 0, 0);
    tick();
    fu_done_valid = '0;
    chk("single_not_early", 128'(cdb_valid), 128'(0));
    tick();
    chk("single_k1_valid", 128'(cdb_valid), 128'(3'b001));
    tick();
    chk("single_k2_valid", 128'(cdb_valid), 128'(3'b000));
    tick();

    // Squash while lanes are on the bus and FU4 is still pending
    present(8'h1E);
    push_exp(3, 1, 2, 3);
    tick();
    fu_done_valid = '0;
    tick();
    squash = 1'b1;
    #1 chk("squash_ready", 128'(fu_done_ready), 128'(0));
    tick();
    squash = 1'b0;
    #1;
    chk("post_squash_valid", 128'(cdb_valid), 128'(0));
    chk("post_squash_count", 128'(cdb_count), 128'(0));
    chk("post_squash_ready", 128'(fu_done_ready), 128'(8'hFF));
    repeat (4) tick();

    // Tag-0 result from FU3
    ftag[3] = '0; fval[3] = 32'h1234_5678;
    present(8'h08);
`ifndef CDB_NOTAG_DROP_EN
    push_exp(1, 3, 0, 0);
`endif
    tick();
    chk("tag0_ready3", 128'(fu_done_ready[3]), 128'(1));
    fu_done_valid = '0;
    repeat (4) tick();

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_broadcast.md
Name: cdb_broadcast

Overview:
- Producer side of the Common Data Bus.
- Collects completed results from the NUM_FU functional units and holds them in one buffer slot per FU.
- Selects up to SS_SIZE results each cycle with rotating priority and drives them on the SS_SIZE CDB lanes.
- The RS tag CAM, map table and ROB consume those lanes.
- FUs are backpressured with a per-FU ready when their buffer slot cannot drain.

Parameters:
NUM_FU, 8, number of functional-unit completion ports (ALU0-2, LD, ST, MULT0-1, BR)
SS_SIZE, 3, number of CDB lanes broadcast per cycle
TAG_W, 7, physical register tag width (PHYS_REG)
DATA_W, 32, result value width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
squash  in  1  pipeline flush; discards all pending and outgoing results
fu_done_valid  in  NUM_FU  FU i presents a completed result
fu_done_tag  in  NUM_FU x TAG_W  destination physical tag per FU
fu_done_value  in  NUM_FU x DATA_W  result value per FU
fu_done_ready  out  NUM_FU  FU i result accepted this cycle if valid
cdb_valid  out  SS_SIZE  lane j carries a broadcast (drives RS CAM_en)
cdb_tag  out  SS_SIZE x TAG_W  broadcast tag per lane (drives RS CDB_in)
cdb_value  out  SS_SIZE x DATA_W  broadcast value per lane
cdb_count  out  clog2(SS_SIZE+1)  number of valid lanes this cycle

Behaviour:
- State:
  - per-FU slot: occ[i], tag[i], value[i]
  - rr_ptr, clog2(NUM_FU) bits
  - registered lane outputs
- Reset (async, reset=0):
  - occ=0, rr_ptr=0
  - cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_count=0
  - fu_done_ready is combinational, so it reads all-ones once squash=0
- Handshake:
  - fu_done_ready[i] = !squash & (!occ[i] | grant[i]).
  - Transfer occurs at the edge where valid[i] & ready[i]; tag and value are captured into slot i and occ[i] is set.
  - An FU holding valid with ready=0 keeps its tag and value stable.
- Arbitration (combinational, from occ):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first SS_SIZE occupied slots are granted.
  - The k-th grant in scan order goes to lane k; lanes are packed from 0 and unused lanes are invalid.
- Edge after grant:
  - Granted slots load the lane output registers and occ is cleared, unless the same FU refills that slot at the same edge.
  - cdb_count = number of grants.
  - Lanes without a grant: valid=0, tag=0, value=0.
- rr_ptr update:
  - If any grant, rr_ptr <= (index of last grant + 1) mod NUM_FU.
  - Otherwise rr_ptr holds.
- Latency:
  - FU handshake at edge k gives broadcast visible after edge k+1, held for exactly one cycle.
  - Sustained throughput is 1 result per cycle per FU while total demand is at most SS_SIZE.
- Overload (more than SS_SIZE occupied): ungranted slots stay occupied and their FU sees ready=0 if it presents a new result.
  - Starvation bound: every occupied slot is granted within ceil(NUM_FU/SS_SIZE) cycles.
- squash=1:
  - fu_done_ready=0, so no transfers.
  - At the edge, all occ cleared and all cdb_valid cleared, cdb_count=0.
  - rr_ptr holds.
  - Lanes already on the bus during the squash cycle remain visible for that cycle.
- Reset asserted mid-operation: all pending results are dropped immediately (async), with no partial broadcast.
- Duplicate tags from two FUs are not checked; both are broadcast.

Optional Feature:
- Macro CDB_NOTAG_DROP_EN.
- Defined: a handshake with fu_done_tag == 0 (zero register, no destination: stores, branches) completes normally. Nothing is captured, the slot stays empty, no lane is consumed and ready stays 1.
- Undefined: tag-0 results are buffered and broadcast like any other.

Test Plan:
- Reset: hold reset=0 over 3 edges, release -> cdb_valid=000, cdb_count=0, fu_done_ready=8'hFF.
- Single result: FU0 valid, tag 7'h45, value 32'hDEADBEEF for one cycle at edge k -> after edge k+1 cdb_valid=001, cdb_tag[0]=7'h45, cdb_value[0]=32'hDEADBEEF; after edge k+2 cdb_valid=000.
- Overload: FU0-FU4 valid at the same edge, rr_ptr=0
  - next cycle: lanes 0,1,2 = FU0,FU1,FU2; ready[3], ready[4] low if those FUs present new results
  - following cycle: lanes 0,1 = FU3,FU4, cdb_count=2
  - rr_ptr then reads 5
- Rotation: rr_ptr=5, slots FU0, FU1, FU2, FU7 occupied -> lanes = FU7, FU0, FU1; rr_ptr<=2; next cycle lane 0 = FU2.
- Squash: 4 slots occupied, squash=1 for one cycle -> next edge cdb_valid=000, occ empty, no stale tag broadcast afterwards, ready=8'hFF.
- Macro: FU3 presents tag 0
  - with CDB_NOTAG_DROP_EN: never broadcast, ready[3] stays 1
  - without: broadcast on lane 0 with tag 0.
